abm_multi_send_ctl: RTL

ABM_MULTI_SEND_CTL -- requirements
Module: abm_multi_send_ctl

---
 rtl/abm_multi_send_ctl.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/abm_multi_send_ctl.sv
// -----------------------------------------------------------------------------
// abm_multi_send_ctl
//
// Purpose
//   AXI4-Lite controlled launcher for NCH ABM copy channels. Software writes a
//   bit mask to START. Each selected channel that is free gets a one-cycle
//   start strobe. The channel then waits (ARM) for its engine to leave idle.
//   It tracks the run (RUN) and counts the completions. Launch attempts on a
//   busy or non-idle channel set a sticky reject bit. An engine that never
//   leaves idle within ARM_TO cycles sets a sticky timeout bit.
//
// Register map (index = byte address / 4; other indices give DECERR)
//   0      START   W: launch mask        R: busy mask
//   1      STATUS  R: [7:0] idle_in, [15:8] reject, [23:16] timeout
//                  W: write-1-to-clear of [23:8]
//   2      IRQ     (ABM_IRQ_EN only) R: [7:0] pending, [15:8] enable
//                  W: [15:8] -> enable, write-1 to [7:0] clears pending
//   4+n    COUNT n R: 16-bit done count (saturating), W: any write clears
//
// Build option
//   ABM_IRQ_EN : when defined, adds pending/enable registers and drives irq.
//                When undefined, irq is tied low and index 2 decodes as DECERR.
//
// Ports
//   clk, resetn          clock, synchronous active-low reset
//   start[NCH]           per-channel start strobe (registered, one cycle)
//   idle_in[NCH]         per-channel engine idle (1 = idle)
//   irq                  completion interrupt (registered)
//   S_AXI_*              AXI4-Lite slave (AW-bit address, 32-bit data)
// -----------------------------------------------------------------------------
module abm_multi_send_ctl #(
    parameter int AW     = 8,
    parameter int NCH    = 4,
    parameter int ARM_TO = 255
) (
    input  logic           clk,
    input  logic           resetn,
    output logic [NCH-1:0] start,
    input  logic [NCH-1:0] idle_in,
    output logic           irq,
    input  logic [AW-1:0]  S_AXI_AWADDR,
    input  logic [2:0]     S_AXI_AWPROT,
    input  logic           S_AXI_AWVALID,
    output logic           S_AXI_AWREADY,
    input  logic [31:0]    S_AXI_WDATA,
    input  logic [3:0]     S_AXI_WSTRB,
    input  logic           S_AXI_WVALID,
    output logic           S_AXI_WREADY,
    output logic [1:0]     S_AXI_BRESP,
    output logic           S_AXI_BVALID,
    input  logic           S_AXI_BREADY,
    input  logic [AW-1:0]  S_AXI_ARADDR,
    input  logic [2:0]     S_AXI_ARPROT,
    input  logic           S_AXI_ARVALID,
    output logic           S_AXI_ARREADY,
    output logic [31:0]    S_AXI_RDATA,
    output logic [1:0]     S_AXI_RRESP,
    output logic           S_AXI_RVALID,
    input  logic           S_AXI_RREADY
);

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [15:0] ARM_LAST    = 16'(ARM_TO - 1);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;
`ifdef ABM_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } ch_state_t;

    // Per-channel status gathered for the register file
    logic [NCH-1:0] busy;
    logic [NCH-1:0] reject;
    logic [NCH-1:0] timeout;
    logic [NCH-1:0] ch_done;
    logic [15:0]    done_cnt [NCH];

    // ------------------------------------------------------------------
    // Write path: address and data are taken together in one handshake.
    // A new write waits until the previous response has been accepted.
    // ------------------------------------------------------------------
    logic           bvalid_q;
    logic [1:0]     bresp_q;
    logic           wr_fire;
    logic [31:0]    wr_idx;
    logic [31:0]    wdata_m;
    logic           wr_start;
    logic           wr_status;
    logic           wr_hit;
    logic [NCH-1:0] wr_cnt_clr;
    logic [NCH-1:0] rej_clr;
    logic [NCH-1:0] to_clr;

    assign wr_fire       = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign S_AXI_AWREADY = wr_fire;
    assign S_AXI_WREADY  = wr_fire;
    assign wr_idx        = 32'(S_AXI_AWADDR[AW-1:2]);
    // Byte lanes without a strobe behave as if written with zeros
    assign wdata_m       = S_AXI_WDATA & {{8{S_AXI_WSTRB[3]}}, {8{S_AXI_WSTRB[2]}},
                                          {8{S_AXI_WSTRB[1]}}, {8{S_AXI_WSTRB[0]}}};
    assign wr_start      = wr_fire && (wr_idx == 32'd0);
    assign wr_status     = wr_fire && (wr_idx == 32'd1);
    assign rej_clr       = wr_status ? wdata_m[8 +: NCH]  : '0;
    assign to_clr        = wr_status ? wdata_m[16 +: NCH] : '0;
    assign wr_hit        = (wr_idx == 32'd0) || (wr_idx == 32'd1) ||
                           (HAS_IRQ && (wr_idx == 32'd2)) || (|wr_cnt_clr);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_hit ? RESP_OKAY : RESP_DECERR;
        end else if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;

    // ------------------------------------------------------------------
    // Channel FSMs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        ch_state_t   state_q;
        logic [15:0] arm_cnt_q;
        logic [15:0] done_cnt_q;
        logic        start_q;
        logic        reject_q;
        logic        timeout_q;
        logic        launch_req;
        logic        run_done;

        assign wr_cnt_clr[gi] = wr_fire && (wr_idx == 32'(4 + gi));
        assign launch_req     = wr_start & wdata_m[gi];
        assign run_done       = (state_q == ST_RUN) && idle_in[gi];

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state_q    <= ST_IDLE;
                arm_cnt_q  <= '0;
                done_cnt_q <= '0;
                start_q    <= 1'b0;
                reject_q   <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                start_q <= 1'b0;
                // Clears first; any set below overrides in the same cycle
                if (rej_clr[gi]) reject_q  <= 1'b0;
                if (to_clr[gi])  timeout_q <= 1'b0;
                if (wr_cnt_clr[gi]) done_cnt_q <= '0;

                case (state_q)
                    ST_IDLE: begin
                        if (launch_req) begin
                            if (idle_in[gi]) begin
                                state_q   <= ST_ARM;
                                start_q   <= 1'b1;
                                arm_cnt_q <= '0;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    ST_ARM: begin
                        if (launch_req) reject_q <= 1'b1;
                        if (!idle_in[gi]) begin
                            state_q <= ST_RUN;
                        end else if (arm_cnt_q == ARM_LAST) begin
                            state_q   <= ST_IDLE;
                            timeout_q <= 1'b1;
                        end else begin
                            arm_cnt_q <= arm_cnt_q + 16'd1;
                        end
                    end
                    ST_RUN: begin
                        if (launch_req) reject_q <= 1'b1;
                        if (idle_in[gi]) begin
                            state_q <= ST_IDLE;
                            // A clear in the same cycle leaves the count at zero
                            if (!wr_cnt_clr[gi] && (done_cnt_q != CNT_MAX)) begin
                                done_cnt_q <= done_cnt_q + 16'd1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign start[gi]    = start_q;
        assign busy[gi]     = (state_q != ST_IDLE);
        assign reject[gi]   = reject_q;
        assign timeout[gi]  = timeout_q;
        assign done_cnt[gi] = done_cnt_q;
        assign ch_done[gi]  = run_done;
    end

    // ------------------------------------------------------------------
    // Completion interrupt
    // ------------------------------------------------------------------
`ifdef ABM_IRQ_EN
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] enable_q;
    logic           irq_q;
    logic           wr_irq;

    assign wr_irq = wr_fire && (wr_idx == 32'd2);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pending_q <= '0;
            enable_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_irq && S_AXI_WSTRB[1]) enable_q <= wdata_m[8 +: NCH];
            // New completions win over a simultaneous clear
            pending_q <= (pending_q & ~(wr_irq ? wdata_m[0 +: NCH] : '0)) | ch_done;
            irq_q     <= |(pending_q & enable_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read path: one outstanding read, data registered at the handshake
    // ------------------------------------------------------------------
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rd_fire;
    logic [31:0] rd_idx;
    logic [31:0] rd_data_d;
    logic [1:0]  rd_resp_d;

    assign rd_fire       = S_AXI_ARVALID & ~rvalid_q;
    assign S_AXI_ARREADY = ~rvalid_q;
    assign rd_idx        = 32'(S_AXI_ARADDR[AW-1:2]);

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_OKAY;
        if (rd_idx == 32'd0) begin
            rd_data_d[0 +: NCH] = busy;
        end else if (rd_idx == 32'd1) begin
            rd_data_d[0 +: NCH]  = idle_in;
            rd_data_d[8 +: NCH]  = reject;
            rd_data_d[16 +: NCH] = timeout;
`ifdef ABM_IRQ_EN
        end else if (rd_idx == 32'd2) begin
            rd_data_d[0 +: NCH] = pending_q;
            rd_data_d[8 +: NCH] = enable_q;
`endif
        end else begin
            rd_resp_d = RESP_DECERR;
            for (int n = 0; n < NCH; n++) begin
                if (rd_idx == 32'(4 + n)) begin
                    rd_data_d[15:0] = done_cnt[n];
                    rd_resp_d       = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_data_d;
            rresp_q  <= rd_resp_d;
        end else if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
        end
    end

    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    // Protection bits and byte offsets carry no meaning for this block
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], wdata_m
`ifndef ABM_IRQ_EN
                           , ch_done
`endif
                          };

endmodule
